// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: config FSM states and the
// packed FIFO entry format {fe, pe, data}.
package uart_pkg;

  typedef enum logic {
    CFG_IDLE,
    CFG_WAIT
  } cfg_state_t;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic RX_DS_8BIT = 1'b1;

endpackage

// File: rtl/rx_fifo.sv
// Parametrised synchronous FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage has no reset; the head is masked by the owner while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rx_controller.sv
// RX sequencer: shadows CSR config and applies it only between frames,
// and queues completed frames with their error flags for the CSR read path.
module rx_controller
  import uart_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] ACC_INCR_RST = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_wr_i,
  input  logic [15:0] cfg_acc_incr_i,
  input  logic        cfg_ds_i,
  input  logic [1:0]  cfg_p_i,
  input  logic        cfg_s_i,
  output logic        cfg_pending_o,
  output logic [15:0] cr_acc_incr_o,
  output logic        cr_ds_o,
  output logic [1:0]  cr_p_o,
  output logic        cr_s_o,
  input  logic        frontend_busy_i,
  input  logic [10:0] frame_i,
  input  logic        parity_err_i,
  input  logic        frame_err_i,
  input  logic        frame_valid_i,
  input  logic        rx_en_i,
  input  logic        flush_i,
  input  logic        rx_pop_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_pe_o,
  output logic        rx_fe_o,
  output logic        rxne_o,
  output logic        rxfull_o,
  output logic        overrun_o,
  input  logic        ov_clear_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  cfg_state_t  state, next_state;
  logic [15:0] sh_acc_incr;
  logic        sh_ds;
  logic [1:0]  sh_p;
  logic        sh_s;
  logic        apply;

  rx_entry_t   wr_entry;
  rx_entry_t   head;
  logic [9:0]  head_raw;
  logic [CW-1:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        drop;
  logic        unused_frame_bits;

  always_comb begin
    next_state = state;
    apply      = 1'b0;
    if (cfg_wr_i) begin
      next_state = CFG_WAIT;
    end else if (state == CFG_WAIT && !frontend_busy_i) begin
      apply      = 1'b1;
      next_state = CFG_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= CFG_IDLE;
      sh_acc_incr   <= ACC_INCR_RST;
      sh_ds         <= RX_DS_8BIT;
      sh_p          <= '0;
      sh_s          <= 1'b0;
      cr_acc_incr_o <= ACC_INCR_RST;
      cr_ds_o       <= RX_DS_8BIT;
      cr_p_o        <= '0;
      cr_s_o        <= 1'b0;
    end else begin
      state <= next_state;
      if (cfg_wr_i) begin
        sh_acc_incr <= cfg_acc_incr_i;
        sh_ds       <= cfg_ds_i;
        sh_p        <= cfg_p_i;
        sh_s        <= cfg_s_i;
      end
      if (apply) begin
        cr_acc_incr_o <= sh_acc_incr;
        cr_ds_o       <= sh_ds;
        cr_p_o        <= sh_p;
        cr_s_o        <= sh_s;
      end
    end
  end

  assign cfg_pending_o = (state == CFG_WAIT);

  // Data width follows the config that is live when the frame completes.
  assign wr_entry.fe   = frame_err_i;
  assign wr_entry.pe   = parity_err_i;
  assign wr_entry.data = (cr_ds_o == RX_DS_8BIT) ? frame_i[7:0] : {1'b0, frame_i[6:0]};
  assign unused_frame_bits = ^frame_i[10:8];

  assign push_req = frame_valid_i && rx_en_i;
  assign drop     = push_req && !flush_i && fifo_full && !rx_pop_i;

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push_req),
    .pop     (rx_pop_i),
    .flush   (flush_i),
    .wr_data (wr_entry),
    .rd_data (head_raw),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          overrun_o <= 1'b0;
    else if (drop)       overrun_o <= 1'b1;
    else if (ov_clear_i) overrun_o <= 1'b0;
  end

  assign head      = fifo_empty ? rx_entry_t'('0) : rx_entry_t'(head_raw);
  assign rx_data_o = head.data;
  assign rx_pe_o   = head.pe;
  assign rx_fe_o   = head.fe;
  assign rxne_o    = (fifo_count != '0);
  assign rxfull_o  = fifo_full;

endmodule

// File: tb/tb_rx_controller.sv
// Self-checking bench for rx_controller: directed scenarios plus a random
// traffic run compared against a queue-based reference model.
module tb_rx_controller;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_wr_i;
  logic [15:0] cfg_acc_incr_i;
  logic        cfg_ds_i;
  logic [1:0]  cfg_p_i;
  logic        cfg_s_i;
  logic        cfg_pending_o;
  logic [15:0] cr_acc_incr_o;
  logic        cr_ds_o;
  logic [1:0]  cr_p_o;
  logic        cr_s_o;
  logic        frontend_busy_i;
  logic [10:0] frame_i;
  logic        parity_err_i;
  logic        frame_err_i;
  logic        frame_valid_i;
  logic        rx_en_i;
  logic        flush_i;
  logic        rx_pop_i;
  logic [7:0]  rx_data_o;
  logic        rx_pe_o;
  logic        rx_fe_o;
  logic        rxne_o;
  logic        rxfull_o;
  logic        overrun_o;
  logic        ov_clear_i;

  int checks = 0;
  int errors = 0;

  logic [9:0] mq[$];
  logic       model_ov;
  logic       model_ds;

  rx_controller #(.DEPTH(DEPTH), .ACC_INCR_RST(16'h0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_wr_i(cfg_wr_i), .cfg_acc_incr_i(cfg_acc_incr_i), .cfg_ds_i(cfg_ds_i),
    .cfg_p_i(cfg_p_i), .cfg_s_i(cfg_s_i), .cfg_pending_o(cfg_pending_o),
    .cr_acc_incr_o(cr_acc_incr_o), .cr_ds_o(cr_ds_o), .cr_p_o(cr_p_o), .cr_s_o(cr_s_o),
    .frontend_busy_i(frontend_busy_i), .frame_i(frame_i),
    .parity_err_i(parity_err_i), .frame_err_i(frame_err_i),
    .frame_valid_i(frame_valid_i), .rx_en_i(rx_en_i), .flush_i(flush_i),
    .rx_pop_i(rx_pop_i), .rx_data_o(rx_data_o), .rx_pe_o(rx_pe_o), .rx_fe_o(rx_fe_o),
    .rxne_o(rxne_o), .rxfull_o(rxfull_o), .overrun_o(overrun_o), .ov_clear_i(ov_clear_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a FIFO as a queue, updated from the inputs seen at an edge.
  function automatic void model_step();
    logic       want_push;
    logic       can_pop;
    logic       dropped;
    logic [7:0] d;
    want_push = frame_valid_i && rx_en_i;
    dropped   = 1'b0;
    if (flush_i) begin
      mq.delete();
    end else begin
      can_pop = rx_pop_i && (mq.size() > 0);
      d = model_ds ? 8'(frame_i % 256) : 8'(frame_i % 128);
      if (want_push && mq.size() == DEPTH && !can_pop) dropped = 1'b1;
      if (can_pop) void'(mq.pop_front());
      if (want_push && !dropped) mq.push_back({frame_err_i, parity_err_i, d});
    end
    if (dropped) model_ov = 1'b1;
    else if (ov_clear_i) model_ov = 1'b0;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    cfg_wr_i      = 1'b0;
    frame_valid_i = 1'b0;
    rx_pop_i      = 1'b0;
    flush_i       = 1'b0;
    ov_clear_i    = 1'b0;
    parity_err_i  = 1'b0;
    frame_err_i   = 1'b0;
  endtask

  task automatic send_frame(input logic [10:0] f, input logic pe, input logic fe, input logic pop);
    frame_i       = f;
    parity_err_i  = pe;
    frame_err_i   = fe;
    frame_valid_i = 1'b1;
    rx_pop_i      = pop;
    cycle();
  endtask

  task automatic pop_one();
    rx_pop_i = 1'b1;
    cycle();
  endtask

  task automatic write_cfg(input logic [15:0] acc, input logic ds, input logic [1:0] p, input logic s);
    cfg_wr_i       = 1'b1;
    cfg_acc_incr_i = acc;
    cfg_ds_i       = ds;
    cfg_p_i        = p;
    cfg_s_i        = s;
    cycle();
  endtask

  task automatic test_reset();
    checks++; if (cfg_pending_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b exp 0", cfg_pending_o); end
    checks++; if (cr_acc_incr_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_acc got %h exp 0000", cr_acc_incr_o); end
    checks++; if (cr_ds_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ds got %b exp 1", cr_ds_o); end
    checks++; if ({cr_p_o, cr_s_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ps got %b exp 000", {cr_p_o, cr_s_o}); end
    checks++; if ({rxne_o, rxfull_o, overrun_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status got %b exp 000", {rxne_o, rxfull_o, overrun_o}); end
    checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h000) begin errors++; $display("[TB] FAIL reset_head got %h exp 000", {rx_fe_o, rx_pe_o, rx_data_o}); end
  endtask

  task automatic test_config();
    frontend_busy_i = 1'b1;
    write_cfg(16'hAAAA, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) write_cfg(16'h1234, 1'b1, 2'd2, 1'b1);
      else cycle();
      checks++; if (cr_acc_incr_o !== 16'h0000) begin errors++; $display("[TB] FAIL cfg_busy_acc cyc %0d got %h exp 0000", i, cr_acc_incr_o); end
      checks++; if (cfg_pending_o !== 1'b1) begin errors++; $display("[TB] FAIL cfg_busy_pending cyc %0d got %b exp 1", i, cfg_pending_o); end
    end
    frontend_busy_i = 1'b0;
    cycle();
    cycle();
    checks++; if (cr_acc_incr_o !== 16'h1234) begin errors++; $display("[TB] FAIL cfg_applied_acc got %h exp 1234", cr_acc_incr_o); end
    checks++; if ({cr_p_o, cr_s_o} !== 3'b101) begin errors++; $display("[TB] FAIL cfg_applied_ps got %b exp 101", {cr_p_o, cr_s_o}); end
    checks++; if (cfg_pending_o !== 1'b0) begin errors++; $display("[TB] FAIL cfg_done_pending got %b exp 0", cfg_pending_o); end
  endtask

  task automatic test_data7();
    write_cfg(16'h0100, 1'b0, 2'd0, 1'b0);
    checks++; if (cr_acc_incr_o !== 16'h1234) begin errors++; $display("[TB] FAIL cfg_lat1_acc got %h exp 1234", cr_acc_incr_o); end
    cycle();
    checks++; if ({cr_acc_incr_o, cr_ds_o} !== {16'h0100, 1'b0}) begin errors++; $display("[TB] FAIL cfg_lat2 got %h/%b exp 0100/0", cr_acc_incr_o, cr_ds_o); end
    model_ds = 1'b0;
    send_frame(11'h7FF, 1'b0, 1'b0, 1'b0);
    checks++; if ({rxne_o, rx_data_o} !== {1'b1, 8'h7F}) begin errors++; $display("[TB] FAIL data7 got %b/%h exp 1/7f", rxne_o, rx_data_o); end
    pop_one();
    checks++; if (rxne_o !== 1'b0) begin errors++; $display("[TB] FAIL data7_pop got %b exp 0", rxne_o); end
  endtask

  task automatic test_errors();
    logic [10:0] f1, f2;
    f1 = 11'($urandom);
    f2 = 11'($urandom);
    send_frame(f1, 1'b1, 1'b0, 1'b0);
    send_frame(f2, 1'b0, 1'b1, 1'b0);
    checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== {2'b01, 8'(f1 % 128)}) begin errors++; $display("[TB] FAIL err_first got %b%b/%h exp 01/%h", rx_fe_o, rx_pe_o, rx_data_o, 8'(f1 % 128)); end
    pop_one();
    checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== {2'b10, 8'(f2 % 128)}) begin errors++; $display("[TB] FAIL err_second got %b%b/%h exp 10/%h", rx_fe_o, rx_pe_o, rx_data_o, 8'(f2 % 128)); end
    pop_one();
    write_cfg(16'h0100, 1'b1, 2'd0, 1'b0);
    cycle();
    model_ds = 1'b1;
    checks++; if (cr_ds_o !== 1'b1) begin errors++; $display("[TB] FAIL ds_restore got %b exp 1", cr_ds_o); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(11'(i), 1'b0, 1'b0, 1'b0);
    checks++; if ({rxfull_o, overrun_o} !== 2'b11) begin errors++; $display("[TB] FAIL ovr_status got %b exp 11", {rxfull_o, overrun_o}); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (rx_data_o !== 8'(i)) begin errors++; $display("[TB] FAIL ovr_pop%0d got %h exp %h", i, rx_data_o, 8'(i)); end
      pop_one();
    end
    checks++; if ({rxne_o, overrun_o} !== 2'b01) begin errors++; $display("[TB] FAIL ovr_drained got %b exp 01", {rxne_o, overrun_o}); end
    ov_clear_i = 1'b1;
    cycle();
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL ov_clear got %b exp 0", overrun_o); end
    for (int i = 1; i <= DEPTH; i++) send_frame(11'(i), 1'b0, 1'b0, 1'b0);
    send_frame(11'h005, 1'b0, 1'b0, 1'b1);
    checks++; if ({rxfull_o, overrun_o, rx_data_o} !== {2'b10, 8'h02}) begin errors++; $display("[TB] FAIL full_pushpop got %b%b/%h exp 10/02", rxfull_o, overrun_o, rx_data_o); end
    flush_i = 1'b1;
    cycle();
  endtask

  task automatic test_flush_disable();
    for (int i = 0; i < 3; i++) send_frame(11'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (rxne_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre got %b exp 1", rxne_o); end
    flush_i = 1'b1;
    cycle();
    checks++; if ({rxne_o, rx_data_o} !== 9'h000) begin errors++; $display("[TB] FAIL flush got %b/%h exp 0/00", rxne_o, rx_data_o); end
    rx_en_i = 1'b0;
    send_frame(11'h0A5, 1'b0, 1'b0, 1'b0);
    checks++; if (rxne_o !== 1'b0) begin errors++; $display("[TB] FAIL rx_disabled got %b exp 0", rxne_o); end
    rx_en_i = 1'b1;
  endtask

  task automatic test_random();
    logic [9:0] exp_head;
    for (int n = 0; n < 400; n++) begin
      frame_i         = 11'($urandom);
      parity_err_i    = ($urandom_range(0, 3) == 0);
      frame_err_i     = ($urandom_range(0, 3) == 0);
      frame_valid_i   = ($urandom_range(0, 1) == 1);
      rx_en_i         = ($urandom_range(0, 9) != 0);
      rx_pop_i        = ($urandom_range(0, 9) < 4);
      flush_i         = ($urandom_range(0, 19) == 0);
      ov_clear_i      = ($urandom_range(0, 9) == 0);
      frontend_busy_i = ($urandom_range(0, 1) == 1);
      cycle();
      exp_head = (mq.size() > 0) ? mq[0] : 10'h000;
      checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== exp_head) begin errors++; $display("[TB] FAIL rnd_head n=%0d got %h exp %h", n, {rx_fe_o, rx_pe_o, rx_data_o}, exp_head); end
      checks++; if ({rxne_o, rxfull_o} !== {mq.size() > 0, mq.size() == DEPTH}) begin errors++; $display("[TB] FAIL rnd_status n=%0d got %b exp %b", n, {rxne_o, rxfull_o}, {mq.size() > 0, mq.size() == DEPTH}); end
      checks++; if (overrun_o !== model_ov) begin errors++; $display("[TB] FAIL rnd_overrun n=%0d got %b exp %b", n, overrun_o, model_ov); end
    end
    rx_en_i         = 1'b1;
    frontend_busy_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_frame(11'h033, 1'b1, 1'b0, 1'b0);
    frontend_busy_i = 1'b1;
    write_cfg(16'h5555, 1'b0, 2'd3, 1'b1);
    rst_i = 1'b0;
    #1;
    mq.delete();
    model_ov = 1'b0;
    model_ds = 1'b1;
    test_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    frontend_busy_i = 1'b0;
    cycle();
    cycle();
    checks++; if ({cr_acc_incr_o, cr_ds_o, cfg_pending_o} !== {16'h0000, 2'b10}) begin errors++; $display("[TB] FAIL shadow_discard got %h/%b%b exp 0000/10", cr_acc_incr_o, cr_ds_o, cfg_pending_o); end
  endtask

  initial begin
    rst_i = 1'b0;
    cfg_wr_i = 1'b0; cfg_acc_incr_i = '0; cfg_ds_i = 1'b1; cfg_p_i = '0; cfg_s_i = 1'b0;
    frontend_busy_i = 1'b0; frame_i = '0; parity_err_i = 1'b0; frame_err_i = 1'b0;
    frame_valid_i = 1'b0; rx_en_i = 1'b1; flush_i = 1'b0; rx_pop_i = 1'b0; ov_clear_i = 1'b0;
    model_ov = 1'b0;
    model_ds = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    rst_i = 1'b1;
    cycle();
    test_config();
    test_data7();
    test_errors();
    test_overrun();
    test_flush_disable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
